vend_150: RTL and testbench

VEND_150 -- requirements
Module: vend_150

---
 rtl/vend150_pkg.sv | 42 ++++
 rtl/vend150_coin_in.sv | 69 ++++++
 rtl/vend_150.sv | 86 ++++++++
 tb/tb_vend_150.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vend150_pkg.sv
// ---------------------------------------------------------------------------
// vend150_pkg
// Shared types and constants for the 150-yen vending controller.
//   state_e   : credit held between purchases (S0 = 0, S50 = 50, S100 = 100 yen)
//   PRICE     : item price in yen
//   COIN0     : value of the c0 coin in yen
//   COIN1     : value of the c1 coin in yen
//   credit_of : yen value represented by a credit state
//   state_of  : credit state representing a yen amount below PRICE
// ---------------------------------------------------------------------------
package vend150_pkg;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S50  = 2'd1,
        S100 = 2'd2
    } state_e;

    localparam int unsigned PRICE = 150;
    localparam int unsigned COIN0 = 50;
    localparam int unsigned COIN1 = 100;

    function automatic int unsigned credit_of(state_e s);
        case (s)
            S50:     return COIN0;
            S100:    return COIN1;
            default: return 0;
        endcase
    endfunction

    // Only amounts below PRICE are ever stored, so 0/50/100 covers every case.
    function automatic state_e state_of(int unsigned yen);
        if (yen >= COIN1) begin
            return S100;
        end else if (yen >= COIN0) begin
            return S50;
        end else begin
            return S0;
        end
    endfunction

endpackage

// File: rtl/vend150_coin_in.sv
// ---------------------------------------------------------------------------
// vend150_coin_in
// Conditions one coin input and produces a single-cycle strobe for every
// 0->1 transition seen at the sampling clock edge. A level held high counts
// once. Reset clears the history, so an input already high when reset
// releases is reported as a fresh coin.
// Build option: define VEND150_SYNC_EN to pass the input through a two-flop
// synchronizer first (two extra cycles of latency).
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   coin : raw coin input
//   rise : combinational strobe, high in the cycle a new coin is sampled
// ---------------------------------------------------------------------------
module vend150_coin_in (
    input  logic clk,
    input  logic rst,
    input  logic coin,
    output logic rise
);

    logic sampled;
    logic prev_q;
    logic prev_d;

`ifdef VEND150_SYNC_EN
    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;

    // Next values of the synchronizer chain: the raw input shifts in.
    always_comb begin
        sync1_d = coin;
        sync2_d = sync1_q;
    end

    // Synchronizer flops, cleared by reset so a held input looks new afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sampled = sync2_q;
`else
    assign sampled = coin;
`endif

    // History of the value seen at the previous edge.
    always_comb begin
        prev_d = sampled;
    end

    // Edge-detect history register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sampled & ~prev_q;

endmodule

// File: rtl/vend_150.sv
// ---------------------------------------------------------------------------
// vend_150
// 150-yen vending controller accepting 50-yen (c0) and 100-yen (c1) coins.
// Credit is held as S0/S50/S100; reaching 150 dispenses, 200 also returns
// 50 yen change. Outputs are registered one-cycle pulses.
// Build option: VEND150_SYNC_EN adds a two-flop synchronizer on each coin.
//   ck  : rising-edge clock
//   res : asynchronous active-high reset
//   c0  : 50-yen coin inserted
//   c1  : 100-yen coin inserted
//   y0  : dispense item pulse
//   y1  : return 50-yen change pulse
// ---------------------------------------------------------------------------
module vend_150
    import vend150_pkg::*;
(
    input  logic ck,
    input  logic res,
    input  logic c0,
    input  logic c1,
    output logic y0,
    output logic y1
);

    logic        c0_rise;
    logic        c1_rise;
    state_e      state_q;
    state_e      state_d;
    logic        y0_q;
    logic        y0_d;
    logic        y1_q;
    logic        y1_d;
    int unsigned total_yen;

    vend150_coin_in u_coin0 (
        .clk  (ck),
        .rst  (res),
        .coin (c0),
        .rise (c0_rise)
    );

    vend150_coin_in u_coin1 (
        .clk  (ck),
        .rst  (res),
        .coin (c1),
        .rise (c1_rise)
    );

    // Add the coin seen this cycle to the stored credit. When both coins
    // arrive together the 100-yen coin wins and the 50 is dropped. Reaching
    // the price clears credit; any excess (at most 50) is returned as change.
    always_comb begin
        total_yen = credit_of(state_q);
        if (c1_rise) begin
            total_yen = total_yen + COIN1;
        end else if (c0_rise) begin
            total_yen = total_yen + COIN0;
        end

        state_d = state_of(total_yen);
        y0_d    = 1'b0;
        y1_d    = 1'b0;
        if (total_yen >= PRICE) begin
            state_d = S0;
            y0_d    = 1'b1;
            y1_d    = (total_yen > PRICE);
        end
    end

    // Credit state and registered output pulses.
    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            state_q <= S0;
            y0_q    <= 1'b0;
            y1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
        end
    end

    assign y0 = y0_q;
    assign y1 = y1_q;

endmodule

// File: tb/tb_vend_150.sv
// ---------------------------------------------------------------------------
// tb_vend_150
// Self-checking bench for vend_150. A yen-based reference model runs beside
// the DUT and is compared every cycle; directed sequences add literal
// expectations at the interesting cycles. Honours VEND150_SYNC_EN.
// ---------------------------------------------------------------------------
module tb_vend_150;

`ifdef VEND150_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic ck  = 1'b0;
    logic res = 1'b0;
    logic c0  = 1'b0;
    logic c1  = 1'b0;
    logic y0;
    logic y1;

    int tests_run    = 0;
    int tests_failed = 0;

    vend_150 dut (
        .ck  (ck),
        .res (res),
        .c0  (c0),
        .c1  (c1),
        .y0  (y0),
        .y1  (y1)
    );

    always #5 ck = ~ck;

    // Reference model: credit in yen, inputs delayed by the synchronizer depth.
    int   credit = 0;
    logic q0[$];
    logic q1[$];
    logic prev0  = 1'b0;
    logic prev1  = 1'b0;
    logic exp_y0 = 1'b0;
    logic exp_y1 = 1'b0;

    always @(posedge ck or posedge res) begin
        logic s0;
        logic s1;
        if (res) begin
            credit = 0;
            q0.delete();
            q1.delete();
            prev0  = 1'b0;
            prev1  = 1'b0;
            exp_y0 = 1'b0;
            exp_y1 = 1'b0;
        end else begin
            q0.push_back(c0);
            q1.push_back(c1);
            s0 = (q0.size() > LAT) ? q0.pop_front() : 1'b0;
            s1 = (q1.size() > LAT) ? q1.pop_front() : 1'b0;
            exp_y0 = 1'b0;
            exp_y1 = 1'b0;
            if (s1 && !prev1) begin
                credit = credit + 100;
            end else if (s0 && !prev0) begin
                credit = credit + 50;
            end
            prev0 = s0;
            prev1 = s1;
            if (credit >= 150) begin
                exp_y0 = 1'b1;
                exp_y1 = ((credit - 150) == 50);
                credit = 0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(posedge ck) begin
        #1;
        tests_run = tests_run + 1;
        if (y0 !== exp_y0 || y1 !== exp_y1) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL cycle_cmp t=%0t got y0=%b y1=%b want y0=%b y1=%b",
                     $time, y0, y1, exp_y0, exp_y1);
        end
    end

    // Drive both coin inputs at a falling edge and hold them for n rising edges.
    task automatic applyStimulus(input logic a, input logic b, input int n);
        @(negedge ck);
        c0 = a;
        c1 = b;
        repeat (n) @(posedge ck);
        #1;
    endtask

    // Let inputs ride through the synchronizer depth.
    task automatic waitLatency();
        repeat (LAT) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic e0, input logic e1);
        tests_run = tests_run + 1;
        if (y0 !== e0 || y1 !== e1) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s got y0=%b y1=%b want y0=%b y1=%b",
                     name, y0, y1, e0, e1);
        end
    endtask

    task automatic coinPulse(input string name, input logic a, input logic b,
                             input logic e0, input logic e1);
        applyStimulus(a, b, 1);
        waitLatency();
        checkOutput(name, e0, e1);
        applyStimulus(1'b0, 1'b0, 1);
    endtask

    task automatic pulseReset();
        @(negedge ck);
        res = 1'b1;
        @(posedge ck);
        #1;
        checkOutput("reset_hold", 1'b0, 1'b0);
        @(negedge ck);
        res = 1'b0;
    endtask

    initial begin
        #1;
        res = 1'b1;
        repeat (2) @(posedge ck);
        #1;
        checkOutput("reset_state", 1'b0, 1'b0);
        @(negedge ck);
        res = 1'b0;

        // Three 50-yen coins: dispense only after the third, no change.
        coinPulse("r26_first", 1'b1, 1'b0, 1'b0, 1'b0);
        coinPulse("r26_second", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("r26_early", (LAT == 0), 1'b0);
        waitLatency();
        checkOutput("r26_dispense", 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("r26_one_cycle", 1'b0, 1'b0);

        // Two 100-yen coins: dispense plus change together.
        coinPulse("r27_first", 1'b0, 1'b1, 1'b0, 1'b0);
        coinPulse("r27_second", 1'b0, 1'b1, 1'b1, 1'b1);

        // 50 then 100, and 100 then 50: exact price.
        coinPulse("r28a_50", 1'b1, 1'b0, 1'b0, 1'b0);
        coinPulse("r28a_100", 1'b0, 1'b1, 1'b1, 1'b0);
        coinPulse("r28b_100", 1'b0, 1'b1, 1'b0, 1'b0);
        coinPulse("r28b_50", 1'b1, 1'b0, 1'b1, 1'b0);

        // Held 50-yen input counts once; a 100 then lands exactly on price.
        applyStimulus(1'b1, 1'b0, 5);
        waitLatency();
        checkOutput("r29_held", 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1);
        coinPulse("r29_then_100", 1'b0, 1'b1, 1'b1, 1'b0);

        // Simultaneous coins keep only the 100; reset discards it.
        coinPulse("r30_both", 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (LAT) applyStimulus(1'b0, 1'b0, 1);
        pulseReset();
        coinPulse("r30_after_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        coinPulse("r30_then_100", 1'b0, 1'b1, 1'b1, 1'b0);

        // A pulse that is low again before the rising edge is ignored.
        @(negedge ck);
        c0 = 1'b1;
        #2;
        c0 = 1'b0;
        @(posedge ck);
        #1;
        coinPulse("glitch_then_100", 1'b0, 1'b1, 1'b0, 1'b0);
        coinPulse("glitch_then_50", 1'b1, 1'b0, 1'b1, 1'b0);

        // Coin already high when reset releases counts as new.
        @(negedge ck);
        res = 1'b1;
        c0  = 1'b1;
        @(posedge ck);
        #1;
        @(negedge ck);
        res = 1'b0;
        @(posedge ck);
        #1;
        waitLatency();
        checkOutput("r21_held_coin", 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1);
        coinPulse("r21_then_100", 1'b0, 1'b1, 1'b1, 1'b0);

        repeat (4) applyStimulus(1'b0, 1'b0, 1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
